irqctrl_wb8: RTL and testbench

Interrupt controller placed directly upstream of the CPU's `INTERRUPT_I` input. It aggregates up to eight peripheral interrupt lines into the single CPU interrupt request: timer, UART, IR decoder and future sources. Each line is synchronised, edge- or level-qualified, latched and masked. The block is an 8-bit Wishbone slave decoded by the top-level arbiter at 0xFFFFFAxx, which is a previously reserved slot.

---
 rtl/irqctrl_wb8.sv | 105 ++++++++++
 tb/tb_irqctrl_wb8.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irqctrl_wb8.sv
// Eight-line interrupt aggregator behind an 8-bit Wishbone slave.
// Lines are synchronised, qualified as level or rising edge, latched into PENDING and masked by ENABLE.
module irqctrl_wb8 #(
   parameter int NSOURCES = 8
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic [1:0]          ADR_I,
   input  logic [7:0]          DAT_I,
   input  logic                STB_I,
   input  logic                WE_I,
   output logic [7:0]          DAT_O,
   output logic                ACK_O,
   input  logic [NSOURCES-1:0] I_irq,
   output logic                O_interrupt
);

   localparam logic [7:0] IMPL = 8'((9'd1 << NSOURCES) - 9'd1);

   logic [7:0] r_s1, r_s2, r_prev;
   logic [7:0] r_pending, r_enable, r_mode;
   logic [7:0] r_dat;
   logic       r_ack;
   logic       r_int;

   logic [7:0] w_irq;
   logic       w_acc;
   logic       w_wr;
   logic [7:0] w_clr;
   logic [7:0] w_rise;
   logic [7:0] w_pend_nxt;
   logic [7:0] w_act;
   logic       w_any;
   logic [2:0] w_id;
   logic [7:0] w_rdata;

   always_comb begin
      w_irq = '0;
      w_irq[NSOURCES-1:0] = I_irq;
   end

   // A held strobe sees ACK_O high on the following cycle and is therefore not re-accepted.
   assign w_acc  = STB_I & ~r_ack;
   assign w_wr   = w_acc & WE_I;
   assign w_clr  = (w_wr && ADR_I == 2'd0) ? DAT_I : 8'h00;
   assign w_rise = r_s2 & ~r_prev;

   // Edge sources hold until cleared (a new edge beats the clear); level sources track the line.
   assign w_pend_nxt = ((r_mode & (w_rise | (r_pending & ~w_clr))) | (~r_mode & r_s2)) & IMPL;

   assign w_act = r_pending & r_enable;
   assign w_any = |w_act;

   always_comb begin
      w_id = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_act[i]) w_id = 3'(i);
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      case (ADR_I)
         2'd0: w_rdata = r_pending;
         2'd1: w_rdata = r_enable;
         2'd2: w_rdata = r_mode;
         2'd3: w_rdata = {w_any, 4'b0000, w_id};
         default: w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_s1      <= 8'h00;
         r_s2      <= 8'h00;
         r_prev    <= 8'h00;
         r_pending <= 8'h00;
         r_enable  <= 8'h00;
         r_mode    <= 8'h00;
         r_dat     <= 8'h00;
         r_ack     <= 1'b0;
         r_int     <= 1'b0;
      end else begin
         r_s1      <= w_irq & IMPL;
         r_s2      <= r_s1;
         r_prev    <= r_s2;
         r_pending <= w_pend_nxt;
         r_ack     <= w_acc;
         r_int     <= w_any;
         if (w_acc) r_dat <= w_rdata;
         if (w_wr) begin
            case (ADR_I)
               2'd1: r_enable <= DAT_I & IMPL;
               2'd2: r_mode   <= DAT_I & IMPL;
               default: ;
            endcase
         end
      end
   end

   assign DAT_O       = r_dat;
   assign ACK_O       = r_ack;
   assign O_interrupt = r_int;

endmodule

// File: tb/tb_irqctrl_wb8.sv
// Directed scenarios plus randomized traffic for irqctrl_wb8, checked against a cycle-level reference model.
module tb_irqctrl_wb8;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] adr;
   logic [7:0] dat_w;
   logic       stb;
   logic       we;
   logic [7:0] dat_r;
   logic       ack;
   logic [7:0] irq;
   logic       intr;

   int n_checks = 0;
   int n_pass   = 0;

   irqctrl_wb8 #(.NSOURCES(8)) dut (
      .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat_w), .STB_I(stb), .WE_I(we),
      .DAT_O(dat_r), .ACK_O(ack), .I_irq(irq), .O_interrupt(intr)
   );

   always #5 clk = ~clk;

   // Reference model: the controller sees each pin two clocks late (h1) and
   // compares against the value one clock older still (h2) to find a rising edge.
   logic [7:0] h0, h1, h2;
   logic [7:0] m_pend, m_en, m_mode, m_dat;
   logic       m_ack, m_int;
   logic [7:0] mv_seen, mv_rise, mv_clr, mv_next, mv_act, mv_rd;
   logic       mv_acc;
   int         mv_id;

   initial begin
      h0 = 0; h1 = 0; h2 = 0;
      m_pend = 0; m_en = 0; m_mode = 0; m_dat = 0; m_ack = 0; m_int = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            h0 = 0; h1 = 0; h2 = 0;
            m_pend = 0; m_en = 0; m_mode = 0; m_dat = 0; m_ack = 0; m_int = 0;
         end else begin
            mv_seen = h1;
            mv_rise = h1 & ~h2;
            mv_acc  = stb && !m_ack;
            mv_clr  = (mv_acc && we && adr == 2'd0) ? dat_w : 8'h00;
            for (int i = 0; i < 8; i++) begin
               if (m_mode[i]) mv_next[i] = mv_rise[i] || (m_pend[i] && !mv_clr[i]);
               else           mv_next[i] = mv_seen[i];
            end
            mv_act = m_pend & m_en;
            mv_id  = 0;
            for (int i = 0; i < 8; i++) begin
               if (mv_act[i]) begin
                  mv_id = i;
                  break;
               end
            end
            case (adr)
               2'd0: mv_rd = m_pend;
               2'd1: mv_rd = m_en;
               2'd2: mv_rd = m_mode;
               default: mv_rd = (mv_act != 0) ? (8'h80 + 8'(mv_id)) : 8'h00;
            endcase
            m_int = (mv_act != 0);
            m_ack = mv_acc;
            if (mv_acc) m_dat = mv_rd;
            if (mv_acc && we && adr == 2'd1) m_en = dat_w;
            if (mv_acc && we && adr == 2'd2) m_mode = dat_w;
            m_pend = mv_next;
            h2 = h1; h1 = h0; h0 = irq;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // One complete access; returns one cycle after the ACK so ACK_O is low again.
   task automatic bus(input logic [1:0] a, input logic w, input logic [7:0] d,
                      output logic [7:0] q, output logic k);
      adr = a; we = w; dat_w = d; stb = 1'b1;
      tick(1);
      q = dat_r;
      k = ack;
      stb = 1'b0; we = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      logic [7:0] q;
      logic       k;
      rst = 1'b1; irq = 8'hFF; stb = 1'b0; we = 1'b0; adr = 0; dat_w = 0;
      tick(2);
      n_checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
      n_checks++; if (dat_r !== 8'h00) $display("FAIL reset_dat: got %h want 00", dat_r); else n_pass++;
      n_checks++; if (intr !== 1'b0) $display("FAIL reset_int: got %b want 0", intr); else n_pass++;
      rst = 1'b0; irq = 8'h00;
      tick(3);
      for (int r = 0; r < 4; r++) begin
         bus(2'(r), 1'b0, 8'h00, q, k);
         n_checks++;
         if (q !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", r, q); else n_pass++;
      end
   endtask

   task automatic test_edge_latch();
      logic [7:0] q;
      logic       k;
      bus(2'd2, 1'b1, 8'h01, q, k);
      bus(2'd1, 1'b1, 8'h01, q, k);
      irq[0] = 1'b1;
      tick(2);
      irq[0] = 1'b0;
      tick(1);
      n_checks++; if (intr !== 1'b0) $display("FAIL edge_early: got %b want 0", intr); else n_pass++;
      tick(1);
      n_checks++; if (intr !== 1'b1) $display("FAIL edge_latency: got %b want 1", intr); else n_pass++;
      tick(5);
      n_checks++; if (intr !== 1'b1) $display("FAIL edge_hold: got %b want 1", intr); else n_pass++;
      bus(2'd3, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h80) $display("FAIL edge_active: got %h want 80", q); else n_pass++;
      bus(2'd0, 1'b1, 8'h01, q, k);
      n_checks++; if (intr !== 1'b0) $display("FAIL edge_clear: got %b want 0", intr); else n_pass++;
      bus(2'd0, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h00) $display("FAIL edge_pend_clr: got %h want 00", q); else n_pass++;
   endtask

   task automatic test_level();
      logic [7:0] q;
      logic       k;
      bus(2'd2, 1'b1, 8'h00, q, k);
      bus(2'd1, 1'b1, 8'h04, q, k);
      irq[2] = 1'b1;
      tick(4);
      bus(2'd0, 1'b1, 8'h04, q, k);
      bus(2'd0, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h04) $display("FAIL level_pend: got %h want 04", q); else n_pass++;
      n_checks++; if (intr !== 1'b1) $display("FAIL level_int: got %b want 1", intr); else n_pass++;
      irq[2] = 1'b0;
      tick(4);
      n_checks++; if (intr !== 1'b0) $display("FAIL level_drop: got %b want 0", intr); else n_pass++;
   endtask

   task automatic test_priority_mask();
      logic [7:0] q;
      logic       k;
      bus(2'd2, 1'b1, 8'hFF, q, k);
      bus(2'd0, 1'b1, 8'hFF, q, k);
      irq[5] = 1'b1; irq[3] = 1'b1;
      tick(2);
      irq[5] = 1'b0; irq[3] = 1'b0;
      tick(4);
      bus(2'd1, 1'b1, 8'h20, q, k);
      bus(2'd3, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h85) $display("FAIL prio_src5: got %h want 85", q); else n_pass++;
      bus(2'd1, 1'b1, 8'h28, q, k);
      bus(2'd3, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h83) $display("FAIL prio_src3: got %h want 83", q); else n_pass++;
      bus(2'd1, 1'b1, 8'h00, q, k);
      n_checks++; if (intr !== 1'b0) $display("FAIL mask_int: got %b want 0", intr); else n_pass++;
      bus(2'd3, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h00) $display("FAIL mask_active: got %h want 00", q); else n_pass++;
      bus(2'd0, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h28) $display("FAIL mask_pend: got %h want 28", q); else n_pass++;
   endtask

   task automatic test_set_clear_collision();
      logic [7:0] q;
      logic       k;
      bus(2'd0, 1'b1, 8'hFF, q, k);
      irq[1] = 1'b1;
      tick(2);
      bus(2'd0, 1'b1, 8'h02, q, k);
      bus(2'd0, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h02) $display("FAIL collide_set_wins: got %h want 02", q); else n_pass++;
      irq[1] = 1'b0;
      bus(2'd0, 1'b1, 8'h02, q, k);
      bus(2'd0, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h00) $display("FAIL collide_later_clear: got %h want 00", q); else n_pass++;
   endtask

   task automatic test_bus_protocol();
      logic [7:0] q;
      logic       k;
      logic [3:0] pat;
      bus(2'd1, 1'b1, 8'h5A, q, k);
      adr = 2'd1; we = 1'b0; stb = 1'b1;
      pat[3] = ack;
      tick(1);
      pat[2] = ack;
      n_checks++; if (dat_r !== 8'h5A) $display("FAIL held_read_data: got %h want 5a", dat_r); else n_pass++;
      tick(1);
      pat[1] = ack;
      tick(1);
      pat[0] = ack;
      stb = 1'b0;
      tick(1);
      n_checks++; if (pat !== 4'b0101) $display("FAIL held_ack_pattern: got %b want 0101", pat); else n_pass++;
      bus(2'd3, 1'b1, 8'hFF, q, k);
      n_checks++; if (k !== 1'b1) $display("FAIL ro_write_ack: got %b want 1", k); else n_pass++;
      bus(2'd1, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h5A) $display("FAIL ro_write_enable: got %h want 5a", q); else n_pass++;
      bus(2'd2, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'hFF) $display("FAIL ro_write_mode: got %h want ff", q); else n_pass++;
      adr = 2'd1; we = 1'b1; dat_w = 8'h33; stb = 1'b1; rst = 1'b1;
      tick(1);
      n_checks++; if (ack !== 1'b0) $display("FAIL rst_ack_suppressed: got %b want 0", ack); else n_pass++;
      rst = 1'b0; stb = 1'b0; we = 1'b0;
      tick(1);
      bus(2'd1, 1'b0, 8'h00, q, k);
      n_checks++; if (q !== 8'h00) $display("FAIL rst_write_dropped: got %h want 00", q); else n_pass++;
   endtask

   task automatic test_random();
      int n_fail_rnd;
      n_fail_rnd = 0;
      for (int c = 0; c < 3000; c++) begin
         n_checks++;
         if (ack !== m_ack) begin
            if (n_fail_rnd < 10) $display("FAIL rnd_ack cyc %0d: got %b want %b", c, ack, m_ack);
            n_fail_rnd++;
         end else n_pass++;
         n_checks++;
         if (dat_r !== m_dat) begin
            if (n_fail_rnd < 10) $display("FAIL rnd_dat cyc %0d: got %h want %h", c, dat_r, m_dat);
            n_fail_rnd++;
         end else n_pass++;
         n_checks++;
         if (intr !== m_int) begin
            if (n_fail_rnd < 10) $display("FAIL rnd_int cyc %0d: got %b want %b", c, intr, m_int);
            n_fail_rnd++;
         end else n_pass++;
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
         end
         rst = ($urandom_range(0, 99) == 0);
         if (!stb) begin
            if ($urandom_range(0, 2) == 0) begin
               stb = 1'b1;
               adr = 2'($urandom_range(0, 3));
               we = 1'($urandom_range(0, 1));
               dat_w = 8'($urandom_range(0, 255));
            end
         end else if ($urandom_range(0, 1) == 0) begin
            stb = 1'b0;
         end
         tick(1);
      end
      rst = 1'b0; stb = 1'b0;
      tick(1);
   endtask

   initial begin
      rst = 1'b1; irq = 8'h00; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
      #2;
      test_reset();
      test_edge_latch();
      test_level();
      test_priority_mask();
      test_set_clear_collision();
      test_bus_protocol();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
